// File: rtl/cam_req_sequencer_if.sv
// cam_req_sequencer_if: request, register-file and response channels of the sequencer
//   req_*  producer request channel (valid/ready, op, key, new value)
//   cam_*  control strobes to, and match results from, the CAM register file
//   rsp_*  response channel to the consumer (valid/ready, op, hit, min, max)
interface cam_req_sequencer_if;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [3:0] req_key;
    logic [3:0] req_new;
    logic [3:0] cam_D_lookup;
    logic       cam_setD;
    logic [3:0] cam_newD;
    logic       cam_init;
    logic       cam_valid;
    logic [2:0] cam_minAddr;
    logic [2:0] cam_maxAddr;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [1:0] rsp_op;
    logic       rsp_hit;
    logic [2:0] rsp_min;
    logic [2:0] rsp_max;
    modport slave (
        input  req_valid, req_op, req_key, req_new, cam_valid, cam_minAddr, cam_maxAddr, rsp_ready,
        output req_ready, cam_D_lookup, cam_setD, cam_newD, cam_init, rsp_valid, rsp_op, rsp_hit, rsp_min, rsp_max
    );
    modport master (
        output req_valid, req_op, req_key, req_new, cam_valid, cam_minAddr, cam_maxAddr, rsp_ready,
        input  req_ready, cam_D_lookup, cam_setD, cam_newD, cam_init, rsp_valid, rsp_op, rsp_hit, rsp_min, rsp_max
    );
endinterface

// File: rtl/cam_req_sequencer.sv
// cam_req_sequencer: FIFO-buffered request front-end for the 8x4 CAM register file
//   clk, reset         clock, synchronous active-high reset
//   bus                request / register-file / response channels
//   hit_cnt, miss_cnt  saturating lookup+replace hit and miss statistics
//   busy               FSM active or requests still queued
module cam_req_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    cam_req_sequencer_if.slave bus,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic               busy
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    state_t      state, state_d;
    logic [9:0]  mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push, pop, counted, lk_hit;
    logic [1:0]  iss_op;
    logic [9:0]  head;
    assign full          = (wr_ptr ^ rd_ptr) == {1'b1, {AW{1'b0}}};
    assign empty         = wr_ptr == rd_ptr;
    assign push          = bus.req_valid && !full;
    assign head          = mem[rd_ptr[AW-1:0]];
    assign bus.req_ready = !full;
    assign bus.rsp_valid = state == RESP;
    assign busy          = state != IDLE || !empty;
    // reserved op 11 behaves as a lookup, so only init is excluded from statistics
    assign counted       = iss_op != 2'b10;
    assign lk_hit        = counted && bus.cam_valid;
    always_comb begin
        state_d = state;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                state_d = empty ? IDLE : ISSUE;
                pop     = !empty;
            end
            ISSUE: state_d = RESP;
            RESP: if (bus.rsp_ready) begin
                state_d = empty ? IDLE : ISSUE;
                pop     = !empty;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk)
        if (push) mem[wr_ptr[AW-1:0]] <= {bus.req_op, bus.req_key, bus.req_new};
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            iss_op           <= '0;
            bus.cam_D_lookup <= '0;
            bus.cam_newD     <= '0;
            bus.cam_setD     <= 1'b0;
            bus.cam_init     <= 1'b0;
            bus.rsp_op       <= '0;
            bus.rsp_hit      <= 1'b0;
            bus.rsp_min      <= '0;
            bus.rsp_max      <= '0;
            hit_cnt          <= '0;
            miss_cnt         <= '0;
        end else begin
            state <= state_d;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            // strobes are registered on the pop edge so they are high exactly for the ISSUE cycle
            bus.cam_setD <= pop && head[9:8] == 2'b01;
            bus.cam_init <= pop && head[9:8] == 2'b10;
            if (pop) begin
                rd_ptr           <= rd_ptr + 1'b1;
                iss_op           <= head[9:8];
                bus.cam_D_lookup <= head[7:4];
                bus.cam_newD     <= head[3:0];
            end
            // match inputs still reflect pre-replace contents at this edge
            if (state == ISSUE) begin
                bus.rsp_op  <= iss_op;
                bus.rsp_hit <= lk_hit;
                bus.rsp_min <= lk_hit ? bus.cam_minAddr : 3'd0;
                bus.rsp_max <= lk_hit ? bus.cam_maxAddr : 3'd0;
                if (lk_hit && hit_cnt != '1) hit_cnt <= hit_cnt + 1'b1;
                if (counted && !bus.cam_valid && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cam_req_sequencer.sv
// tb_cam_req_sequencer: randomized self-checking bench with a CAM register-file emulator and request-level model
module tb_cam_req_sequencer;
    localparam int CW = 3;
    localparam logic [CW-1:0] CMAX = '1;
    typedef struct packed {logic [1:0] op; logic hit; logic [2:0] mn; logic [2:0] mx;} rsp_t;
    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] hit_cnt, miss_cnt;
    logic          busy;
    logic          pushing = 1'b0;
    int            checks = 0, failures = 0, cyc = 0;
    cam_req_sequencer_if bus ();
    cam_req_sequencer #(.DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .busy(busy)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // register-file emulator; reports junk indices on a miss so the zeroing rule is exercised
    logic [3:0] cam [8] = '{default: 4'h0};
    always @(posedge clk)
        if (bus.cam_init) for (int i = 0; i < 8; i++) cam[i] <= 4'(8 + i);
        else if (bus.cam_setD) for (int i = 0; i < 8; i++) if (cam[i] == bus.cam_D_lookup) cam[i] <= bus.cam_newD;
    always_comb begin
        bus.cam_valid   = 1'b0;
        bus.cam_minAddr = 3'd5;
        bus.cam_maxAddr = 3'd6;
        for (int i = 7; i >= 0; i--) if (cam[i] == bus.cam_D_lookup) begin bus.cam_valid = 1'b1; bus.cam_minAddr = 3'(i); end
        for (int i = 0; i < 8; i++) if (cam[i] == bus.cam_D_lookup) bus.cam_maxAddr = 3'(i);
    end

    // monitor: records accepted responses, strobe cycles and stall stability
    rsp_t got_q[$];
    int   got_cyc[$];
    int   n_init_seen = 0, n_set_seen = 0, unstable = 0;
    rsp_t last = '0;
    logic stall = 1'b0;
    always @(negedge clk) begin
        rsp_t cur;
        cur = {bus.rsp_op, bus.rsp_hit, bus.rsp_min, bus.rsp_max};
        if (bus.cam_init) n_init_seen <= n_init_seen + 1;
        if (bus.cam_setD) n_set_seen <= n_set_seen + 1;
        if (stall && bus.rsp_valid && cur !== last) unstable <= unstable + 1;
        stall <= bus.rsp_valid && !bus.rsp_ready && !reset;
        last  <= cur;
        if (bus.rsp_valid && bus.rsp_ready && !reset) begin
            got_q.push_back(cur);
            got_cyc.push_back(cyc);
        end
    end

    // request-level model: each request's answer is fixed by the in-order request history
    logic [3:0]    mdl [8] = '{default: 4'h0};
    rsp_t          exp_q[$];
    logic [CW-1:0] e_hit = '0, e_miss = '0;
    int            e_init = 0, e_set = 0;
    task automatic model(input logic [1:0] op, input logic [3:0] k, input logic [3:0] n);
        rsp_t r;
        logic [7:0] m;
        for (int i = 0; i < 8; i++) m[i] = mdl[i] == k;
        r = '0;
        r.op = op;
        if (op == 2'b10) begin
            for (int i = 0; i < 8; i++) mdl[i] = 4'(8 + i);
            e_init++;
        end else begin
            r.hit = |m;
            for (int i = 7; i >= 0; i--) if (m[i]) r.mn = 3'(i);
            for (int i = 0; i < 8; i++) if (m[i]) r.mx = 3'(i);
            if (r.hit) e_hit = (e_hit == CMAX) ? CMAX : e_hit + 1'b1;
            else e_miss = (e_miss == CMAX) ? CMAX : e_miss + 1'b1;
            if (op == 2'b01) begin
                e_set++;
                for (int i = 0; i < 8; i++) if (m[i]) mdl[i] = n;
            end
        end
        exp_q.push_back(r);
    endtask

    function automatic rsp_t mk(input logic [1:0] op, input logic h, input logic [2:0] a, input logic [2:0] b);
        return {op, h, a, b};
    endfunction

    function automatic rsp_t take();
        rsp_t r = '1;
        if (got_q.size() != 0) r = got_q.pop_front();
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [3:0] k, input logic [3:0] n);
        int t = 0;
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_key   = k;
        bus.req_new   = n;
        while (!bus.req_ready && t < 200) begin tick(); t++; end
        checks++;
        if (!bus.req_ready) begin failures++; $display("FAIL push_timeout: req_ready=%b required 1", bus.req_ready); end
        else model(op, k, n);
        tick();
        bus.req_valid = 1'b0;
    endtask

    task automatic drain(output logic ok);
        int t = 0;
        while ((got_q.size() != exp_q.size() || busy) && t < 500) begin tick(); t++; end
        ok = t < 500;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.rsp_valid, bus.req_ready, busy} !== 3'b010) begin
            failures++; $display("FAIL reset_ctrl: valid/ready/busy=%b required 010", {bus.rsp_valid, bus.req_ready, busy});
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== '0) begin failures++; $display("FAIL reset_cnt: hit=%0d miss=%0d required 0 0", hit_cnt, miss_cnt); end
        checks++;
        if ({bus.cam_setD, bus.cam_init, bus.cam_D_lookup, bus.cam_newD} !== '0) begin
            failures++; $display("FAIL reset_cam: cam=%h required 0", {bus.cam_setD, bus.cam_init, bus.cam_D_lookup, bus.cam_newD});
        end
        checks++;
        if ({bus.rsp_op, bus.rsp_hit, bus.rsp_min, bus.rsp_max} !== '0) begin
            failures++; $display("FAIL reset_rsp: rsp=%h required 0", {bus.rsp_op, bus.rsp_hit, bus.rsp_min, bus.rsp_max});
        end
        reset = 1'b0;
        e_hit = '0;
        e_miss = '0;
        tick();
    endtask

    task automatic test_init();
        logic ok;
        rsp_t g;
        int si = n_init_seen;
        bus.rsp_ready = 1'b1;
        push(2'b10, 4'h0, 4'h0);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL init_drain: responses=%0d required 1", got_q.size()); end
        g = take();
        checks++;
        if (g !== mk(2'b10, 1'b0, 3'd0, 3'd0)) begin failures++; $display("FAIL init_rsp: got %h required %h", g, mk(2'b10, 1'b0, 3'd0, 3'd0)); end
        checks++;
        if (n_init_seen - si !== 1) begin failures++; $display("FAIL init_pulse: cycles=%0d required 1", n_init_seen - si); end
        exp_q.delete();
    endtask

    task automatic test_lookup();
        logic ok;
        rsp_t g;
        push(2'b00, 4'hA, 4'h0);
        tick();
        checks++;
        if ({bus.rsp_valid, bus.cam_D_lookup, bus.cam_setD, bus.cam_init} !== {1'b0, 4'hA, 2'b00}) begin
            failures++; $display("FAIL lookup_issue: valid/key/setD/init=%h required %h", {bus.rsp_valid, bus.cam_D_lookup, bus.cam_setD, bus.cam_init}, {1'b0, 4'hA, 2'b00});
        end
        tick();
        checks++;
        if (bus.rsp_valid !== 1'b1) begin failures++; $display("FAIL lookup_latency: rsp_valid=%b required 1", bus.rsp_valid); end
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL lookup_drain: responses=%0d required 1", got_q.size()); end
        g = take();
        checks++;
        if (g !== mk(2'b00, 1'b1, 3'd2, 3'd2)) begin failures++; $display("FAIL lookup_rsp: got %h required %h", g, mk(2'b00, 1'b1, 3'd2, 3'd2)); end
        checks++;
        if ({hit_cnt, miss_cnt} !== {3'd1, 3'd0}) begin failures++; $display("FAIL lookup_cnt: hit=%0d miss=%0d required 1 0", hit_cnt, miss_cnt); end
        exp_q.delete();
    endtask

    task automatic test_replace();
        logic ok;
        rsp_t g;
        push(2'b01, 4'hA, 4'hC);
        tick();
        checks++;
        if ({bus.cam_setD, bus.cam_init, bus.cam_D_lookup, bus.cam_newD} !== {2'b10, 4'hA, 4'hC}) begin
            failures++; $display("FAIL replace_issue: setD/init/key/new=%h required %h", {bus.cam_setD, bus.cam_init, bus.cam_D_lookup, bus.cam_newD}, {2'b10, 4'hA, 4'hC});
        end
        push(2'b00, 4'hC, 4'h0);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL replace_drain: responses=%0d required 2", got_q.size()); end
        g = take();
        checks++;
        if (g !== mk(2'b01, 1'b1, 3'd2, 3'd2)) begin failures++; $display("FAIL replace_rsp: got %h required %h", g, mk(2'b01, 1'b1, 3'd2, 3'd2)); end
        g = take();
        checks++;
        if (g !== mk(2'b00, 1'b1, 3'd2, 3'd4)) begin failures++; $display("FAIL replace_lookup: got %h required %h", g, mk(2'b00, 1'b1, 3'd2, 3'd4)); end
        checks++;
        if (hit_cnt !== 3'd3) begin failures++; $display("FAIL replace_cnt: hit=%0d required 3", hit_cnt); end
        exp_q.delete();
    endtask

    task automatic test_miss();
        logic ok;
        rsp_t g;
        int ss = n_set_seen;
        push(2'b00, 4'h0, 4'h0);
        push(2'b01, 4'h0, 4'h5);
        push(2'b00, 4'h5, 4'h0);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL miss_drain: responses=%0d required 3", got_q.size()); end
        for (int i = 0; i < 3; i++) begin
            g = take();
            checks++;
            if (g !== mk(i == 1 ? 2'b01 : 2'b00, 1'b0, 3'd0, 3'd0)) begin
                failures++; $display("FAIL miss_rsp%0d: got %h required %h", i, g, mk(i == 1 ? 2'b01 : 2'b00, 1'b0, 3'd0, 3'd0));
            end
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== {3'd3, 3'd3}) begin failures++; $display("FAIL miss_cnt: hit=%0d miss=%0d required 3 3", hit_cnt, miss_cnt); end
        checks++;
        if (n_set_seen - ss !== 1) begin failures++; $display("FAIL miss_setD: pulses=%0d required 1", n_set_seen - ss); end
        exp_q.delete();
    endtask

    task automatic test_back_to_back();
        logic ok;
        logic [5:0] acc;
        logic [1:0] lo;
        logic [3:0] lk, ln;
        rsp_t e, g;
        int bad = 0;
        bus.rsp_ready = 1'b0;
        got_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            lo = 2'($urandom_range(0, 1));
            lk = 4'($urandom_range(8, 15));
            ln = 4'($urandom_range(8, 15));
            bus.req_valid = 1'b1;
            bus.req_op    = lo;
            bus.req_key   = lk;
            bus.req_new   = ln;
            acc[i] = bus.req_ready;
            if (bus.req_ready) model(lo, lk, ln);
            tick();
        end
        bus.req_valid = 1'b0;
        checks++;
        if (acc !== 6'b011111) begin failures++; $display("FAIL b2b_accept: ready pattern=%b required 011111", acc); end
        repeat (6) tick();
        checks++;
        if ({bus.rsp_valid, busy, bus.req_ready, got_q.size() == 0} !== 4'b1101) begin
            failures++; $display("FAIL b2b_stall: valid/busy/ready/none=%b required 1101", {bus.rsp_valid, busy, bus.req_ready, got_q.size() == 0});
        end
        bus.rsp_ready = 1'b1;
        push(lo, lk, ln);
        drain(ok);
        checks++;
        if (!ok || got_q.size() != 6) begin failures++; $display("FAIL b2b_drain: responses=%0d required 6", got_q.size()); end
        for (int i = 0; i + 1 < got_cyc.size(); i++) if (got_cyc[i+1] - got_cyc[i] != 2) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL b2b_rate: bad intervals=%0d required 0", bad); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL b2b_rsp: got %h required %h", g, e); end
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL b2b_stable: changes while stalled=%0d required 0", unstable); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_random();
        logic ok;
        rsp_t e, g;
        int si = n_init_seen, ss = n_set_seen, ei = e_init, es = e_set;
        pushing = 1'b1;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    logic [1:0] op;
                    logic [3:0] k, n;
                    op = 2'($urandom_range(0, 3));
                    if (op == 2'b10 && $urandom_range(0, 3) != 0) op = 2'b00;
                    k = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(8 + $urandom_range(0, 7));
                    n = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'(8 + $urandom_range(0, 7));
                    repeat ($urandom_range(0, 2)) tick();
                    push(op, k, n);
                end
                pushing = 1'b0;
            end
            begin
                while (pushing) begin
                    bus.rsp_ready = $urandom_range(0, 2) != 0;
                    tick();
                end
                bus.rsp_ready = 1'b1;
            end
        join
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rnd_drain: responses=%0d required %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && got_q.size() != 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            checks++;
            if (g !== e) begin failures++; $display("FAIL rnd_rsp: got %h required %h", g, e); end
        end
        checks++;
        if ({hit_cnt, miss_cnt} !== {e_hit, e_miss}) begin
            failures++; $display("FAIL rnd_cnt: hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, e_hit, e_miss);
        end
        checks++;
        if (n_init_seen - si != e_init - ei || n_set_seen - ss != e_set - es) begin
            failures++; $display("FAIL rnd_strobes: init=%0d setD=%0d required %0d %0d", n_init_seen - si, n_set_seen - ss, e_init - ei, e_set - es);
        end
        checks++;
        if (unstable != 0) begin failures++; $display("FAIL rnd_stable: changes while stalled=%0d required 0", unstable); end
        exp_q.delete();
        got_q.delete();
    endtask

    task automatic test_reset_mid();
        logic ok;
        rsp_t e, g;
        int si, ss;
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) push(2'b00, 4'($urandom), 4'h0);
        tick();
        checks++;
        if ({bus.rsp_valid, busy} !== 2'b11) begin failures++; $display("FAIL rstmid_pre: valid/busy=%b required 11", {bus.rsp_valid, busy}); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({bus.rsp_valid, busy, bus.req_ready, hit_cnt, miss_cnt} !== {3'b001, 6'd0}) begin
            failures++; $display("FAIL rstmid_state: valid/busy/ready=%b hit=%0d miss=%0d required 001 0 0", {bus.rsp_valid, busy, bus.req_ready}, hit_cnt, miss_cnt);
        end
        si = n_init_seen;
        ss = n_set_seen;
        repeat (10) tick();
        checks++;
        if (n_init_seen != si || n_set_seen != ss || bus.cam_D_lookup !== 4'h0 || got_q.size() != 0 || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_quiet: strobes=%0d key=%h responses=%0d busy=%b required 0 0 0 0", n_init_seen - si + n_set_seen - ss, bus.cam_D_lookup, got_q.size(), busy);
        end
        exp_q.delete();
        got_q.delete();
        e_hit = '0;
        e_miss = '0;
        bus.rsp_ready = 1'b1;
        push(2'b00, mdl[5], 4'h0);
        drain(ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_drain: responses=%0d required 1", got_q.size()); end
        e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
        g = take();
        checks++;
        if (g !== e) begin failures++; $display("FAIL rstmid_rsp: got %h required %h", g, e); end
        checks++;
        if ({hit_cnt, miss_cnt} !== {e_hit, e_miss}) begin
            failures++; $display("FAIL rstmid_cnt: hit=%0d miss=%0d required %0d %0d", hit_cnt, miss_cnt, e_hit, e_miss);
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 2'b00;
        bus.req_key   = 4'h0;
        bus.req_new   = 4'h0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_init();
        test_lookup();
        test_replace();
        test_miss();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/cam_req_sequencer.md
Name: cam_req_sequencer

Overview:
Upstream request front-end for the 8-entry x 4-bit content-addressable register file. The register file has parallel lookup and replace, and reports valid, minAddr and maxAddr.
- Buffers lookup, replace and init requests from a producer in a small FIFO.
- Issues them to the register file one at a time with registered, glitch-free control strobes.
- Captures the match result and returns it over a valid/ready response channel.
- Keeps saturating hit and miss statistics.

Parameters:
- DEPTH, 4: request FIFO entries; power of two, at least 2.
- CNT_W, 8: width of the hit and miss statistic counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  producer has a request.
- req_ready  out  1  FIFO can accept; equals !full.
- req_op  in  2  00 lookup, 01 replace, 10 init, 11 reserved (treated as lookup).
- req_key  in  4  value to search for (D_lookup).
- req_new  in  4  replacement value (newD); used only by replace.
- cam_D_lookup  out  4  search key to the register file.
- cam_setD  out  1  replace strobe to the register file.
- cam_newD  out  4  replacement data to the register file.
- cam_init  out  1  init strobe to the register file.
- cam_valid  in  1  register file match flag.
- cam_minAddr  in  3  lowest matching register index.
- cam_maxAddr  in  3  highest matching register index.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_op  out  2  op code of the request this response belongs to.
- rsp_hit  out  1  captured match flag.
- rsp_min  out  3  captured lowest match index.
- rsp_max  out  3  captured highest match index.
- hit_cnt  out  CNT_W  saturating count of lookup and replace hits.
- miss_cnt  out  CNT_W  saturating count of lookup and replace misses.
- busy  out  1  high whenever the FSM is not in IDLE or the FIFO is not empty.

Behaviour:
- Reset (synchronous; takes priority over everything, including mid-transaction):
  - FIFO is emptied and the FSM goes to IDLE.
  - All outputs go to 0, except req_ready, which goes to 1.
  - The register file contents are not touched; software must issue an init op to restore them.
- FIFO:
  - A push occurs when req_valid && req_ready.
  - The pop pointer advances on the edge at which the FSM enters ISSUE.
  - Pointers wrap modulo DEPTH. Full and empty are distinguished by an extra pointer bit.
  - No push is possible while full. A push and a pop in the same cycle are both honoured.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - If the FIFO is non-empty: pop the head into the issue register and go to ISSUE.
  - All cam_* strobes are 0 in this state.
- ISSUE (exactly 1 cycle):
  - All cam_* outputs are registered.
  - cam_D_lookup = key.
  - cam_newD = new.
  - cam_setD = 1 only for replace.
  - cam_init = 1 only for init.
  - At the end of the cycle, capture the cam inputs into the response registers and go to RESP.
  - Captured values reflect the pre-update contents, because setD takes effect at the same edge.
- RESP:
  - rsp_valid = 1; all cam strobes = 0; rsp_* are held stable until the handshake.
  - On rsp_valid && rsp_ready with the FIFO non-empty: pop and go directly to ISSUE.
  - On the handshake with the FIFO empty: go to IDLE.
  - Without the handshake: stay in RESP.
- Capture rules:
  - Lookup or replace: rsp_hit = cam_valid.
  - On a hit: rsp_min = cam_minAddr and rsp_max = cam_maxAddr.
  - On a miss: rsp_min = rsp_max = 0.
  - Init: rsp_hit = 0, rsp_min = 0, rsp_max = 0.
- Counters:
  - On capture of a lookup or replace, increment hit_cnt if hit, otherwise miss_cnt.
  - Each counter saturates at 2^CNT_W - 1.
  - Init requests are not counted.
- Latency: from the push edge into an empty FIFO with the FSM in IDLE, rsp_valid rises 2 edges later.
- Throughput: sustained 1 request per 2 cycles with rsp_ready held at 1.
- Replace with no match: cam_setD is still pulsed, the register file is unchanged, and the response reports a miss.
- Ordering: strictly in order; exactly one response per request.

Test Plan:
1. Reset, then push init → cam_init is high for exactly 1 cycle and rsp = {op=10, hit=0, min=0, max=0}. The register file holds 8,9,A,B,C,D,E,F.
2. Lookup key=4'hA → rsp_valid 2 cycles after the push; hit=1, min=2, max=2; hit_cnt=1.
3. Replace key=A, new=C, then lookup C:
   - Replace response: hit=1, min=2, max=2.
   - Lookup response: hit=1, min=2, max=4.
4. Lookup key=0 → hit=0, min=0, max=0, miss_cnt increments. Replace key=0, new=5 → miss, and a following lookup 5 also misses.
5. Hold rsp_ready=0 and present 6 back-to-back requests:
   - 5 are accepted (1 in flight, 4 in the FIFO); req_ready=0 on the 6th.
   - Release rsp_ready → 6 responses in order, one per 2 cycles, rsp_* stable while stalled.
6. Assert reset while in RESP with 3 requests queued → next cycle: rsp_valid=0, busy=0, req_ready=1, counters=0. No further cam strobes occur until a new request is pushed.
